router_pkt_tx: RTL
==================

Name: router_pkt_tx

Overview:
- Packet source that drives the router's input port (data_in / packet_valid / busy / err).
- Accepts a command (destination address, payload length) and buffers the whole payload internally.
- Transmits the packet in router wire format: header byte, payload bytes, parity byte.
- Samples the router's err flag after the parity byte and reports pass/fail per packet.

Parameters:
- MAX_LEN, 63, maximum payload bytes; buffer depth; must be ≤ 63 (6-bit length field).
- ERR_WAIT, 3, cycles after parity byte acceptance before err is sampled.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  2  destination port 0..2
- cmd_len  in  6  payload length 1..MAX_LEN
- cmd_inj_err  in  1  invert transmitted parity byte (error injection)
- cmd_rej  out  1  one-cycle pulse: command rejected
- pl_valid  in  1  payload byte valid
- pl_ready  out  1  high only in LOAD
- pl_data  in  8  payload byte
- busy  in  1  router stall; presented byte is held while high
- err  in  1  router parity error flag
- data_out  out  8  byte to router data_in
- packet_valid  out  1  high for header and payload bytes, low for parity
- tx_done  out  1  one-cycle pulse at end of CHECK
- tx_err  out  1  err value sampled at end of CHECK; held until next tx_done

Behaviour:
- Reset (resetn=0 at a clock edge, any state, including mid-packet):
  - state → IDLE.
  - data_out=0, packet_valid=0, cmd_rej=0, tx_done=0, tx_err=0, counters=0.
  - Buffer contents are don't-care.
- All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, if cmd_len==0, cmd_len>MAX_LEN or cmd_addr==3: pulse cmd_rej next cycle and stay in IDLE.
  - Otherwise latch addr, len and inj_err; header = {cmd_len, cmd_addr}; parity accumulator = header; → LOAD.
- LOAD:
  - pl_ready=1.
  - Each cycle with pl_valid, write pl_data to buf[wr_cnt] and XOR it into parity.
  - When wr_cnt reaches len-1 and that byte is accepted → HEADER.
  - Gaps in pl_valid are allowed.
- HEADER:
  - data_out=header, packet_valid=1.
  - A byte is consumed at an edge where busy==0; it is held stable while busy==1.
  - On consume → PAYLOAD.
- PAYLOAD:
  - data_out=buf[rd_cnt], packet_valid=1; rd_cnt advances on each consume.
  - After byte len-1 is consumed → PARITY.
  - No bubbles while busy is low: one byte per cycle.
- PARITY:
  - data_out = parity ^ {8{inj_err}}, packet_valid=0.
  - Held while busy; on consume → CHECK, and data_out returns to 0.
- CHECK:
  - Count ERR_WAIT cycles.
  - On the last cycle: tx_err ← err, tx_done pulses, → IDLE.
- Boundary cases:
  - len=1: exactly 3 bytes on the wire.
  - len=MAX_LEN: rd_cnt/wr_cnt reach MAX_LEN-1 with no wrap.
  - busy asserted on the final payload byte: byte held, packet_valid stays 1.
  - cmd_valid outside IDLE is ignored (cmd_ready=0).
  - pl_valid outside LOAD is ignored.
- Parity: 8-bit XOR of header and all payload bytes, matching the router's internal parity.

Decomposition:
- Shared router package holds:
  - state enum (IDLE, LOAD, HEADER, PAYLOAD, PARITY, CHECK);
  - header field positions (len [7:2], addr [1:0]);
  - invalid address constant 2'b11.
- One natural sub-module: router_pkt_buf, a MAX_LEN x 8 register array with a synchronous write port and a combinational read port.
- FSM, counters and parity stay in the top module.

Test Plan:
- addr=1, len=3, payload 11,22,33, busy=0:
  - wire shows 0x0D, 0x11, 0x22, 0x33 with packet_valid=1, then 0x0D with packet_valid=0;
  - err=0 gives tx_done with tx_err=0.
- Same packet with busy=1 for 2 cycles during the header and 1 cycle on byte 0x22:
  - each byte held for the stall duration;
  - total wire cycles = 5 + 3;
  - sequence and parity unchanged.
- cmd_addr=3, len=4 → cmd_rej pulse, pl_ready stays 0; cmd_len=0 → cmd_rej pulse.
- addr=2, len=1, payload 0xA5, cmd_inj_err=1:
  - header 0x06;
  - parity byte sent = ~(0x06^0xA5) = 0x5C;
  - err driven 1 → tx_err=1.
- len=63 with pl_valid toggling every other cycle:
  - all 63 bytes transmitted in order;
  - header 0xFC|addr;
  - parity matches a reference XOR.
- resetn=0 during PAYLOAD:
  - next cycle packet_valid=0, data_out=0, cmd_ready=1;
  - a following len=2 packet transmits correctly.

Source files
------------

// File: rtl/router_pkt_tx_pkg.sv
// Shared router definitions: FSM states, header layout, widths and helpers.
package router_pkt_tx_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned ADDR_W = 2;

  // Port 3 does not exist on the router.
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_CHECK
  } state_e;

  // Header byte on the wire: len in [7:2], addr in [1:0].
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } hdr_t;

  function automatic logic [DATA_W-1:0] make_hdr(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
    hdr_t h;
    h.len  = len;
    h.addr = addr;
    return DATA_W'(h);
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Bundle of command, payload, router-wire and status signals of router_pkt_tx.
// master: command/payload source and router model; slave: router_pkt_tx.
interface router_pkt_tx_if;
  import router_pkt_tx_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [LEN_W-1:0]    cmd_len;
  logic                cmd_inj_err;
  logic                cmd_rej;
  logic                pl_valid;
  logic                pl_ready;
  logic [DATA_W-1:0]   pl_data;
  logic                busy;
  logic                err;
  logic [DATA_W-1:0]   data_out;
  logic                packet_valid;
  logic                tx_done;
  logic                tx_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_inj_err, pl_valid, pl_data, busy, err,
    input  cmd_ready, cmd_rej, pl_ready, data_out, packet_valid, tx_done, tx_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_inj_err, pl_valid, pl_data, busy, err,
    output cmd_ready, cmd_rej, pl_ready, data_out, packet_valid, tx_done, tx_err
  );

endinterface

// File: rtl/router_pkt_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write, combinational read.
// Ports: clk, we_i/waddr_i/wdata_i write port, raddr_i/rdata_c_o read port.
module router_pkt_buf
  import router_pkt_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 63
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [LEN_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [LEN_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_c_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents need no reset; every byte is written before it is read.
  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_c_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: takes a command, buffers the payload, sends
// header/payload/parity on the router input and reports the router's err flag.
// Ports: clk, resetn (sync, active low), bus (router_pkt_tx_if.slave).
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 63,
  parameter int unsigned ERR_WAIT = 3
) (
  input  logic             clk,
  input  logic             resetn,
  router_pkt_tx_if.slave   bus
);

  localparam int unsigned WAIT_W = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                inj_q, inj_d;
  logic [DATA_W-1:0]   parity_q, parity_d;
  logic [LEN_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                pv_q, pv_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                pl_ready_q, pl_ready_d;
  logic                cmd_rej_q, cmd_rej_d;
  logic                tx_done_q, tx_done_d;
  logic                tx_err_q, tx_err_d;

  logic                cmd_bad_c, cmd_acc_c;
  logic                wr_last_c, rd_last_c, wait_last_c;
  logic                buf_we_c;
  logic [DATA_W-1:0]   buf_rdata_c;

  assign cmd_bad_c   = (bus.cmd_len == '0) || (32'(bus.cmd_len) > MAX_LEN) ||
                       (bus.cmd_addr == ADDR_INVALID);
  assign cmd_acc_c   = (state_q == ST_IDLE) && bus.cmd_valid && !cmd_bad_c;
  assign wr_last_c   = (wr_cnt_q == len_q - LEN_W'(1));
  assign rd_last_c   = (rd_cnt_q == len_q - LEN_W'(1));
  assign wait_last_c = (wait_cnt_q == WAIT_W'(ERR_WAIT - 1));

  router_pkt_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk       (clk),
    .we_i      (buf_we_c),
    .waddr_i   (wr_cnt_q),
    .wdata_i   (bus.pl_data),
    .raddr_i   (rd_cnt_d),
    .rdata_c_o (buf_rdata_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a wire byte is consumed at any edge with busy low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cmd_acc_c)                   state_d = ST_LOAD;
      ST_LOAD:    if (bus.pl_valid && wr_last_c)   state_d = ST_HEADER;
      ST_HEADER:  if (!bus.busy)                   state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (!bus.busy && rd_last_c)      state_d = ST_PARITY;
      ST_PARITY:  if (!bus.busy)                   state_d = ST_CHECK;
      ST_CHECK:   if (wait_last_c)                 state_d = ST_IDLE;
      default:                                     state_d = ST_IDLE;
    endcase
  end

  // Command latch, buffer write, parity accumulation and counters.
  always_comb begin
    len_d      = len_q;
    addr_d     = addr_q;
    inj_d      = inj_q;
    parity_d   = parity_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wait_cnt_d = wait_cnt_q;
    buf_we_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc_c) begin
          len_d    = bus.cmd_len;
          addr_d   = bus.cmd_addr;
          inj_d    = bus.cmd_inj_err;
          parity_d = make_hdr(bus.cmd_len, bus.cmd_addr);
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (bus.pl_valid) begin
          buf_we_c = 1'b1;
          parity_d = parity_q ^ bus.pl_data;
          wr_cnt_d = wr_last_c ? '0 : wr_cnt_q + LEN_W'(1);
        end
      end
      ST_PAYLOAD: begin
        if (!bus.busy) rd_cnt_d = rd_last_c ? '0 : rd_cnt_q + LEN_W'(1);
      end
      ST_PARITY: wait_cnt_d = '0;
      ST_CHECK:  wait_cnt_d = wait_last_c ? '0 : wait_cnt_q + WAIT_W'(1);
      default: ;
    endcase
  end

  // Output logic; wire outputs follow the state being entered so they are
  // registered yet aligned with state_q.
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    pl_ready_d  = (state_d == ST_LOAD);
    cmd_rej_d   = (state_q == ST_IDLE) && bus.cmd_valid && cmd_bad_c;
    tx_done_d   = 1'b0;
    tx_err_d    = tx_err_q;
    data_out_d  = '0;
    pv_d        = 1'b0;
    if ((state_q == ST_CHECK) && wait_last_c) begin
      tx_done_d = 1'b1;
      tx_err_d  = bus.err;
    end
    case (state_d)
      ST_HEADER: begin
        data_out_d = make_hdr(len_q, addr_q);
        pv_d       = 1'b1;
      end
      ST_PAYLOAD: begin
        data_out_d = buf_rdata_c;
        pv_d       = 1'b1;
      end
      ST_PARITY: data_out_d = parity_q ^ {DATA_W{inj_q}};
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      len_q       <= '0;
      addr_q      <= '0;
      inj_q       <= 1'b0;
      parity_q    <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      data_out_q  <= '0;
      pv_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      pl_ready_q  <= 1'b0;
      cmd_rej_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
    end else begin
      len_q       <= len_d;
      addr_q      <= addr_d;
      inj_q       <= inj_d;
      parity_q    <= parity_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      data_out_q  <= data_out_d;
      pv_q        <= pv_d;
      cmd_ready_q <= cmd_ready_d;
      pl_ready_q  <= pl_ready_d;
      cmd_rej_q   <= cmd_rej_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.packet_valid = pv_q;
  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.pl_ready     = pl_ready_q;
  assign bus.cmd_rej      = cmd_rej_q;
  assign bus.tx_done      = tx_done_q;
  assign bus.tx_err       = tx_err_q;

endmodule
